sda_kernel_run_sequencer: RTL and testbench
===========================================

SDA_KERNEL_RUN_SEQUENCER -- requirements
Module: sda_kernel_run_sequencer

Interface
REQ-001 The block SHALL have parameter CYCLE_COUNT_WIDTH, default 32 (legal 1..32), setting the width of the run-cycle counter.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning (clock and reset first).
- ap_clk  input  1  sole clock; all state updates on the rising edge.
- ap_rst_n  input  1  asynchronous, active-low reset.
- reg_req  input  1  register access request from the AXI slave register selector.
- reg_ack  output  1  single-cycle access-complete pulse.
- reg_write_en  input  1  1 = write, 0 = read; sampled with reg_req.
- reg_addr  input  3  word index: 0 CTRL, 1 GIE, 2 IER, 3 ISR, 4 CYCLES.
- reg_wdata  input  32  write data.
- reg_rdata  output  32  read data, valid while reg_ack=1.
- action_go_valid  output  1  run request to the action core.
- action_go_holdoff  input  1  action core not ready to accept go.
- action_done_valid  input  1  action core completion.
- action_done_stop  output  1  sequencer not ready to accept done.
- ap_interrupt  output  1  level interrupt to the platform.

Function
REQ-003 The go transfer SHALL occur on a cycle with action_go_valid=1 and action_go_holdoff=0; the done transfer SHALL occur on a cycle with action_done_valid=1 and action_done_stop=0.
REQ-004 The FSM SHALL have states IDLE, GO, RUN: IDLE->GO when ap_start=1; GO->RUN on go transfer; RUN->GO on done transfer if auto_restart=1, otherwise RUN->IDLE.
REQ-005 action_go_valid SHALL be 1 only in GO; action_done_stop SHALL be 0 only in RUN (both registered outputs).
REQ-006 CTRL SHALL read as: bit0 ap_start, bit1 ap_done, bit2 ap_idle, bit3 ap_ready, bit7 auto_restart, all other bits 0.
REQ-007 A CTRL write with wdata[0]=1 SHALL set ap_start; wdata[0]=0 SHALL NOT clear it; wdata[7] SHALL load auto_restart.
REQ-008 ap_start SHALL clear on the go transfer unless auto_restart=1, in which case it SHALL remain set.
REQ-009 ap_idle SHALL be 1 exactly when the FSM is in IDLE, updating one cycle after the transition.
REQ-010 ap_ready SHALL pulse high for one cycle following each go transfer.
REQ-011 ap_done SHALL set on each done transfer and SHALL be cleared by a CTRL read (clear-on-read, effective on the reg_ack cycle).
REQ-012 If a done transfer coincides with a CTRL read ack, the read SHALL return the old value and ap_done SHALL be 1 afterwards (set wins).
REQ-013 GIE bit0 and IER bits[1:0] SHALL be plain read/write; all other bits SHALL read 0.
REQ-014 ISR bit0 SHALL set on each done transfer and bit1 on each go transfer, regardless of IER.
REQ-015 ISR writes SHALL toggle bits where wdata=1; a coincident set event SHALL win over the toggle.
REQ-016 ap_interrupt SHALL equal registered GIE[0] & |(IER[1:0] & ISR[1:0]).
REQ-017 CYCLES SHALL clear on go transfer, increment each cycle in RUN, saturate at all-ones, hold otherwise, and be zero-extended to 32 bits on read.
REQ-018 reg_ack SHALL assert exactly one cycle after reg_req is sampled high; reg_req SHALL be ignored while reg_ack=1.
REQ-019 Reads of addresses 5..7 SHALL return 0; writes to them SHALL be acknowledged with no effect.
REQ-020 reg_rdata SHALL be 0 whenever reg_ack=0.

Reset
REQ-021 Asserting ap_rst_n low SHALL immediately force: FSM IDLE, ap_idle=1, all other CTRL/GIE/IER/ISR bits 0, CYCLES 0, reg_ack 0, reg_rdata 0, action_go_valid 0, action_done_stop 1, ap_interrupt 0.
REQ-022 Reset asserted mid-run SHALL abandon the run with no ap_done or ISR update; the first start after release SHALL behave as from a cold reset.

Verification
REQ-023 Write CTRL=0x1, holdoff=1 for 3 cycles then 0, done_valid 10 cycles later -> go_valid high 3 cycles, CYCLES=10, CTRL read=0x6, then next CTRL read=0x4.
REQ-024 GIE=1, IER=0x1, single run -> ap_interrupt rises the cycle after ISR[0] sets; ISR write 0x1 -> ap_interrupt low.
REQ-025 Write CTRL=0x81, three done transfers -> FSM re-enters GO each time, ap_idle stays 0; write CTRL=0x0 -> returns to IDLE after the next done.
REQ-026 done transfer on the same cycle as a CTRL read ack -> read shows bit1=0, next read shows bit1=1.
REQ-027 Pull ap_rst_n low in RUN with CYCLES=5 -> all outputs at reset values asynchronously, CTRL read=0x4, ISR read=0.
REQ-028 Hold RUN with CYCLE_COUNT_WIDTH=4 for 20 cycles -> CYCLES reads 0xF.

Source files
------------

// File: rtl/sda_kernel_run_sequencer.sv
// sda_kernel_run_sequencer: start/done sequencer for one action core.
// Owns the CTRL/GIE/IER/ISR/CYCLES registers and the level interrupt.
//
// Ports:
//   ap_clk, ap_rst_n         clock, async active-low reset
//   reg_req / reg_ack        register access request / 1-cycle completion
//   reg_write_en, reg_addr   access kind and word index (0..4 decoded)
//   reg_wdata / reg_rdata    write data / read data (0 outside reg_ack)
//   action_go_valid          run request, transfers when holdoff=0
//   action_go_holdoff        core cannot take the run request yet
//   action_done_valid        core completion, transfers when stop=0
//   action_done_stop         sequencer cannot take a completion now
//   ap_interrupt             registered level interrupt

module sda_kernel_run_sequencer #(
  parameter int CYCLE_COUNT_WIDTH = 32
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        reg_req,
  output logic        reg_ack,
  input  logic        reg_write_en,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        action_go_valid,
  input  logic        action_go_holdoff,
  input  logic        action_done_valid,
  output logic        action_done_stop,
  output logic        ap_interrupt
);

  localparam int CW = CYCLE_COUNT_WIDTH;
  localparam logic [CW-1:0] CYC_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GO   = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          ap_start_q;
  logic          ap_done_q;
  logic          ap_idle_q;
  logic          ap_ready_q;
  logic          auto_q;
  logic          gie_q;
  logic [1:0]    ier_q;
  logic [1:0]    isr_q;
  logic          irq_q;
  logic [CW-1:0] cyc_q;
  logic          go_valid_q;
  logic          done_stop_q;

  logic          ack_q;
  logic          we_q;
  logic [2:0]    addr_q;
  // wd_q = {wdata[7], wdata[1:0]}: the only write bits any register uses
  logic [2:0]    wd_q;

  logic          start_d;
  logic          done_d;
  logic          auto_d;
  logic          gie_d;
  logic [1:0]    ier_d;
  logic [1:0]    isr_d;
  logic [CW-1:0] cyc_d;

  logic          go_xfer;
  logic          done_xfer;
  logic          take;
  logic          sel_ctrl;
  logic          sel_gie;
  logic          sel_ier;
  logic          sel_isr;
  logic          sel_cyc;
  logic          wr;
  logic          rd;
  logic [31:0]   cyc_ext;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  assign unused_wdata = ^{reg_wdata[31:8], reg_wdata[6:2]};

  assign go_xfer   = go_valid_q & ~action_go_holdoff;
  assign done_xfer = action_done_valid & ~done_stop_q;

  // a request is accepted only while no ack is pending; the access
  // itself takes effect at the end of the ack cycle
  assign take = reg_req & ~ack_q;
  assign wr   = ack_q & we_q;
  assign rd   = ack_q & ~we_q;

  assign sel_ctrl = (addr_q == 3'd0);
  assign sel_gie  = (addr_q == 3'd1);
  assign sel_ier  = (addr_q == 3'd2);
  assign sel_isr  = (addr_q == 3'd3);
  assign sel_cyc  = (addr_q == 3'd4);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (ap_start_q) state_d = S_GO;
      S_GO:   if (go_xfer) state_d = S_RUN;
      S_RUN: begin
        if (done_xfer) state_d = auto_q ? S_GO : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d = ap_start_q;
    done_d  = ap_done_q;
    auto_d  = auto_q;
    gie_d   = gie_q;
    ier_d   = ier_q;
    isr_d   = isr_q;
    cyc_d   = cyc_q;

    if (go_xfer && !auto_q) start_d = 1'b0;
    if (wr && sel_ctrl && wd_q[0]) start_d = 1'b1;
    if (wr && sel_ctrl) auto_d = wd_q[2];

    // clear-on-read first so a coincident completion wins
    if (rd && sel_ctrl) done_d = 1'b0;
    if (done_xfer) done_d = 1'b1;

    if (wr && sel_gie) gie_d = wd_q[0];
    if (wr && sel_ier) ier_d = wd_q[1:0];

    // toggle first so a coincident event sets the bit anyway
    if (wr && sel_isr) isr_d = isr_q ^ wd_q[1:0];
    isr_d = isr_d | {go_xfer, done_xfer};

    if (go_xfer) begin
      cyc_d = '0;
    end else if (state_q == S_RUN && !(&cyc_q)) begin
      cyc_d = cyc_q + CYC_ONE;
    end
  end

  always_comb begin
    cyc_ext = '0;
    cyc_ext[CW-1:0] = cyc_q;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl: begin
        rd_mux = {24'd0, auto_q, 3'd0,
                  ap_ready_q, ap_idle_q,
                  ap_done_q, ap_start_q};
      end
      sel_gie: rd_mux = {31'd0, gie_q};
      sel_ier: rd_mux = {30'd0, ier_q};
      sel_isr: rd_mux = {30'd0, isr_q};
      sel_cyc: rd_mux = cyc_ext;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      go_valid_q  <= 1'b0;
      done_stop_q <= 1'b1;
      ap_start_q  <= 1'b0;
      ap_done_q   <= 1'b0;
      ap_idle_q   <= 1'b1;
      ap_ready_q  <= 1'b0;
      auto_q      <= 1'b0;
      gie_q       <= 1'b0;
      ier_q       <= 2'b00;
      isr_q       <= 2'b00;
      irq_q       <= 1'b0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      go_valid_q  <= (state_d == S_GO);
      done_stop_q <= (state_d != S_RUN);
      ap_start_q  <= start_d;
      ap_done_q   <= done_d;
      ap_idle_q   <= (state_q == S_IDLE);
      ap_ready_q  <= go_xfer;
      auto_q      <= auto_d;
      gie_q       <= gie_d;
      ier_q       <= ier_d;
      isr_q       <= isr_d;
      irq_q       <= gie_q & |(ier_q & isr_q);
      cyc_q       <= cyc_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ack_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= 3'd0;
      wd_q   <= 3'd0;
    end else begin
      ack_q <= take;
      if (take) begin
        we_q   <= reg_write_en;
        addr_q <= reg_addr;
        wd_q   <= {reg_wdata[7], reg_wdata[1:0]};
      end
    end
  end

  assign reg_ack          = ack_q;
  assign reg_rdata        = ack_q ? rd_mux : 32'd0;
  assign action_go_valid  = go_valid_q;
  assign action_done_stop = done_stop_q;
  assign ap_interrupt     = irq_q;

endmodule

// File: tb/tb_sda_kernel_run_sequencer.sv
// Bench for sda_kernel_run_sequencer: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.

module tb_sda_kernel_run_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        reg_req = 1'b0;
  logic        reg_write_en = 1'b0;
  logic [2:0]  reg_addr = 3'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic        action_go_holdoff = 1'b0;
  logic        action_done_valid = 1'b0;

  logic        a_ack, a_go, a_stop, a_irq;
  logic [31:0] a_rdata;
  logic        b_ack, b_go, b_stop, b_irq;
  logic [31:0] b_rdata;

  always #5 ap_clk = ~ap_clk;

  sda_kernel_run_sequencer #(.CYCLE_COUNT_WIDTH(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .reg_req(reg_req), .reg_ack(a_ack),
    .reg_write_en(reg_write_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(a_rdata),
    .action_go_valid(a_go),
    .action_go_holdoff(action_go_holdoff),
    .action_done_valid(action_done_valid),
    .action_done_stop(a_stop),
    .ap_interrupt(a_irq)
  );

  sda_kernel_run_sequencer #(.CYCLE_COUNT_WIDTH(4)) dut4 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .reg_req(reg_req), .reg_ack(b_ack),
    .reg_write_en(reg_write_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(b_rdata),
    .action_go_valid(b_go),
    .action_go_holdoff(action_go_holdoff),
    .action_done_valid(action_done_valid),
    .action_done_stop(b_stop),
    .ap_interrupt(b_irq)
  );

  int checks = 0;
  int errors = 0;
  int go_hi = 0;
  int go_rise = 0;
  logic prev_go = 1'b0;

  // model: mode 0 idle, 1 waiting for go, 2 running
  int        m_st;
  bit        m_start, m_done, m_idle, m_ready, m_auto;
  bit        m_gie, m_irq, m_ack, m_we;
  bit [1:0]  m_ier, m_isr;
  bit [2:0]  m_addr;
  bit [31:0] m_wd;
  longint    m_cnt;

  task automatic m_reset();
    m_st = 0; m_start = 0; m_done = 0; m_idle = 1;
    m_ready = 0; m_auto = 0; m_gie = 0; m_irq = 0;
    m_ack = 0; m_we = 0; m_ier = 0; m_isr = 0;
    m_addr = 0; m_wd = 0; m_cnt = 0;
  endtask

  task automatic m_step();
    bit go_x, dn_x, wr, rd, irq_n;
    int st_n;
    go_x = (m_st == 1) && !action_go_holdoff;
    dn_x = (m_st == 2) && action_done_valid;
    wr = m_ack && m_we;
    rd = m_ack && !m_we;
    irq_n = m_gie && ((m_ier & m_isr) != 2'b00);
    st_n = m_st;
    if (m_st == 0 && m_start) st_n = 1;
    if (go_x) st_n = 2;
    if (dn_x) st_n = m_auto ? 1 : 0;
    m_idle = (m_st == 0);
    m_ready = go_x;
    if (go_x && !m_auto) m_start = 0;
    if (rd && m_addr == 3'd0) m_done = 0;
    if (dn_x) m_done = 1;
    if (wr && m_addr == 3'd3) m_isr = m_isr ^ m_wd[1:0];
    if (dn_x) m_isr[0] = 1'b1;
    if (go_x) m_isr[1] = 1'b1;
    if (go_x) m_cnt = 0;
    else if (m_st == 2) m_cnt = m_cnt + 1;
    if (wr) begin
      case (m_addr)
        3'd0: begin
          if (m_wd[0]) m_start = 1;
          m_auto = m_wd[7];
        end
        3'd1: m_gie = m_wd[0];
        3'd2: m_ier = m_wd[1:0];
        default: ;
      endcase
    end
    m_irq = irq_n;
    m_st = st_n;
    if (reg_req && !m_ack) begin
      m_ack = 1; m_we = reg_write_en;
      m_addr = reg_addr; m_wd = reg_wdata;
    end else begin
      m_ack = 0;
    end
  endtask

  function automatic logic [31:0] m_read(longint cap);
    logic [31:0] v;
    v = '0;
    case (m_addr)
      3'd0: v = {24'd0, m_auto, 3'd0, m_ready, m_idle, m_done, m_start};
      3'd1: v = {31'd0, m_gie};
      3'd2: v = {30'd0, m_ier};
      3'd3: v = {30'd0, m_isr};
      3'd4: v = (m_cnt > cap) ? 32'(cap) : 32'(m_cnt);
      default: v = '0;
    endcase
    return v;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge ap_clk or negedge ap_rst_n);
      if (!ap_rst_n) m_reset();
      else m_step();
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("go_valid", 32'(a_go), 32'(m_st == 1));
    chk("done_stop", 32'(a_stop), 32'(m_st != 2));
    chk("reg_ack", 32'(a_ack), 32'(m_ack));
    chk("reg_rdata", a_rdata, m_ack ? m_read(64'hFFFF_FFFF) : 32'd0);
    chk("irq", 32'(a_irq), 32'(m_irq));
    chk("w4_ack", 32'(b_ack), 32'(m_ack));
    chk("w4_rdata", b_rdata, m_ack ? m_read(15) : 32'd0);
    chk("w4_ctl", 32'({b_go, b_stop, b_irq}),
        32'({m_st == 1, m_st != 2, m_irq}));
    if (a_go) go_hi++;
    if (a_go && !prev_go) go_rise++;
    prev_go = a_go;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge ap_clk);
      compare_all();
      #1;
    end
  endtask

  task automatic acc(input bit we, input bit [2:0] a, input bit [31:0] d,
                     output logic [31:0] ra, output logic [31:0] rb);
    reg_req = 1'b1; reg_write_en = we; reg_addr = a; reg_wdata = d;
    step(1);
    ra = a_rdata; rb = b_rdata;
    reg_req = 1'b0;
    step(1);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_go"}, 32'(a_go), 32'd0);
    chk({tag, "_stop"}, 32'(a_stop), 32'd1);
    chk({tag, "_ack"}, 32'(a_ack), 32'd0);
    chk({tag, "_rdata"}, a_rdata, 32'd0);
    chk({tag, "_irq"}, 32'(a_irq), 32'd0);
  endtask

  logic [31:0] ra, rb;
  int base;

  initial begin
    #1 ap_rst_n = 1'b0;
    #1 check_reset_outputs("rst0");
    step(3);
    ap_rst_n = 1'b1;
    step(2);
    acc(0, 3'd0, 0, ra, rb);
    chk("ctrl_cold", ra, 32'h4);

    // start with holdoff for three GO cycles, done 10 run cycles later
    action_go_holdoff = 1'b1;
    base = go_hi;
    acc(1, 3'd0, 32'h1, ra, rb);
    step(3);
    action_go_holdoff = 1'b0;
    step(10);
    action_done_valid = 1'b1;
    step(1);
    action_done_valid = 1'b0;
    chk("go_valid_cycles", 32'(go_hi - base), 32'd3);
    acc(0, 3'd4, 0, ra, rb);
    chk("cycles_ten", ra, 32'd10);
    chk("cycles_ten_w4", rb, 32'd10);
    acc(0, 3'd0, 0, ra, rb);
    chk("ctrl_done", ra, 32'h6);
    acc(0, 3'd0, 0, ra, rb);
    chk("ctrl_cleared", ra, 32'h4);

    // interrupt path
    acc(1, 3'd3, 32'h3, ra, rb);
    acc(1, 3'd1, 32'h1, ra, rb);
    acc(1, 3'd2, 32'h1, ra, rb);
    acc(0, 3'd3, 0, ra, rb);
    chk("isr_toggled_clear", ra, 32'd0);
    action_done_valid = 1'b1;
    acc(1, 3'd0, 32'h1, ra, rb);
    step(3);
    chk("irq_before", 32'(a_irq), 32'd0);
    step(1);
    chk("irq_rise", 32'(a_irq), 32'd1);
    action_done_valid = 1'b0;
    acc(1, 3'd3, 32'h1, ra, rb);
    step(1);
    chk("irq_fall", 32'(a_irq), 32'd0);
    acc(0, 3'd3, 0, ra, rb);
    chk("isr_go_only", ra, 32'h2);

    // done on the same cycle as a CTRL read ack
    acc(0, 3'd0, 0, ra, rb);
    chk("ctrl_pre_coinc", ra, 32'h6);
    acc(1, 3'd0, 32'h1, ra, rb);
    step(2);
    reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 3'd0;
    step(1);
    ra = a_rdata;
    reg_req = 1'b0;
    action_done_valid = 1'b1;
    chk("ctrl_coinc", ra, 32'h0);
    step(1);
    action_done_valid = 1'b0;
    acc(0, 3'd0, 0, ra, rb);
    chk("ctrl_after_coinc", ra, 32'h6);

    // auto restart
    action_done_valid = 1'b1;
    base = go_rise;
    acc(1, 3'd0, 32'h81, ra, rb);
    for (int i = 0; i < 40 && (go_rise - base) < 4; i++) step(1);
    chk("auto_restarts", 32'((go_rise - base) >= 4), 32'd1);
    acc(0, 3'd0, 0, ra, rb);
    chk("ctrl_auto", ra & 32'h85, 32'h81);
    acc(1, 3'd0, 32'h0, ra, rb);
    step(8);
    action_done_valid = 1'b0;
    step(2);
    chk("auto_off_go", 32'(a_go), 32'd0);
    chk("auto_off_stop", 32'(a_stop), 32'd1);
    acc(0, 3'd0, 0, ra, rb);
    chk("ctrl_auto_off", ra, 32'h6);

    // reset in the middle of a run
    acc(1, 3'd0, 32'h1, ra, rb);
    step(6);
    reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 3'd4;
    step(1);
    ra = a_rdata;
    reg_req = 1'b0;
    chk("cycles_five", ra, 32'd5);
    chk("irq_pre_reset", 32'(a_irq), 32'd1);
    #1 ap_rst_n = 1'b0;
    #1 check_reset_outputs("rst_run");
    step(2);
    ap_rst_n = 1'b1;
    step(1);
    acc(0, 3'd0, 0, ra, rb);
    chk("ctrl_after_rst", ra, 32'h4);
    acc(0, 3'd3, 0, ra, rb);
    chk("isr_after_rst", ra, 32'd0);
    acc(0, 3'd4, 0, ra, rb);
    chk("cycles_after_rst", ra, 32'd0);

    // saturation of the narrow counter
    acc(1, 3'd0, 32'h1, ra, rb);
    step(24);
    acc(0, 3'd4, 0, ra, rb);
    chk("cycles_w32", ra, 32'd23);
    chk("cycles_sat_w4", rb, 32'hF);
    action_done_valid = 1'b1;
    step(2);
    action_done_valid = 1'b0;

    // unmapped addresses
    acc(1, 3'd6, 32'hFFFF_FFFF, ra, rb);
    acc(0, 3'd5, 0, ra, rb);
    chk("unmapped_rd", ra, 32'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reg_req = ($urandom_range(0, 2) == 0);
      reg_write_en = 1'($urandom_range(0, 1));
      reg_addr = 3'($urandom_range(0, 7));
      reg_wdata = $urandom;
      action_go_holdoff = ($urandom_range(0, 2) == 0);
      action_done_valid = ($urandom_range(0, 2) == 0);
      if (!ap_rst_n) ap_rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) ap_rst_n = 1'b0;
      step(1);
    end
    reg_req = 1'b0;
    ap_rst_n = 1'b1;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
